// File: rtl/seg7_number_display.sv
// Multi-digit active-low seven-segment driver: binary load -> sequential double-dabble
// BCD conversion -> stored digits -> formatted (lead blank / overflow dash / blink) hex register.

module seg7_digit (
  input  logic [3:0] digit,
  input  logic       lead_zero,
  input  logic       overflow,
  input  logic       blank_lz,
  input  logic       blank_all,
  output logic [6:0] seg
);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = BLANK;
    endcase
    if (overflow)                    seg = DASH;
    else if (blank_lz && lead_zero)  seg = BLANK;
    if (blank_all)                   seg = BLANK;
  end
endmodule

module seg7_number_display #(
  parameter int WIDTH     = 8,
  parameter int DIGITS    = 3,
  parameter int BLINK_DIV = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);
  localparam int NB   = (WIDTH + 2) / 3;
  localparam int PADN = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       sh;
  logic [4*NB-1:0]        bcd, bcd_adj;
  logic [4*PADN-1:0]      bcd_pad;
  logic [CW-1:0]          cnt;
  logic [DIGITS-1:0][3:0] digits;
  logic                   ovf_next;
  logic [BLINK_DIV-1:0]   blink_cnt;
  logic [DIGITS-1:0]      lead;
  logic                   run;
  logic [7*DIGITS-1:0]    hex_next;

  // add-3 correction applied before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NB; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // widen to cover both the shown digits and any nibbles above them
  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*NB-1:0] = bcd;
    ovf_next = 1'b0;
    for (int k = DIGITS; k < PADN; k++)
      if (bcd_pad[4*k +: 4] != 4'd0) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      digits   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          sh    <= value;
          bcd   <= '0;
          cnt   <= CW'(WIDTH);
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sh} <= {bcd_adj[4*NB-2:0], sh, 1'b0};
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= LATCH;
        end
        LATCH: begin
          for (int k = 0; k < DIGITS; k++) digits[k] <= bcd_pad[4*k +: 4];
          overflow <= ovf_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + BLINK_DIV'(1);
  end

  // lead[k]: digit k and every digit above it are zero; digit 0 never qualifies
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run     = run && (digits[k] == 4'd0);
      lead[k] = run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg7_digit u_dig (
      .digit     (digits[k]),
      .lead_zero (lead[k]),
      .overflow  (overflow),
      .blank_lz  (blank_lz),
      .blank_all (blink_en && blink_cnt[BLINK_DIV-1]),
      .seg       (hex_next[7*k +: 7])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hex <= '1;
    else       hex <= hex_next;
  end
endmodule
